store_dispatch: RTL and testbench
=================================

# store_dispatch

Store-side address decoder and peripheral write block for the pipeline's MEM stage, the write counterpart of the load-data select path. Every store is routed either to data memory or to a memory-mapped peripheral register: seven-segment display, LEDs, timer reload, or the two-word Ethernet transmit staging. A send command starts an Ethernet transmit handshake, tracked by a three-state FSM. The resulting sticky completion flag is read back by software at 0x834.

## Interface
Parameters:
- LED_W, 16, width of LED register (low bits of wdata)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  32  store effective address from MEM stage
- wdata  in  32  store data
- we  in  1  store strobe, one cycle per sw
- dmem_we  out  1  data-memory write enable (combinational)
- seg_data  out  32  seven-segment display register
- led  out  LED_W  LED register
- timer_load  out  32  timer reload value
- timer_load_pulse  out  1  one-cycle strobe after timer_load is written
- eth_tx_data0  out  32  staged Ethernet word 0
- eth_tx_data1  out  32  staged Ethernet word 1
- eth_tx_valid  out  1  transmit request to MAC
- eth_tx_ready  in  1  MAC accepts request
- eth_tx_done  in  1  one-cycle pulse from MAC when the frame has left
- eth_busy  out  1  FSM not IDLE
- eth_send_finish  out  1  sticky completion flag (read at 0x834)

## Operation
- Decode uses addr[11:2] only. Upper address bits and addr[1:0] are ignored. Only whole-word writes are supported.
- If addr[11]==0, the store goes to DMEM: dmem_we = we & ~addr[11].
- If addr[11]==1, the store is a peripheral write and is never forwarded to DMEM. Peripheral map:
  - 0x800: seg_data <= wdata
  - 0x804: led <= wdata[LED_W-1:0]
  - 0x810: timer_load <= wdata; timer_load_pulse high on the next cycle only
  - 0x82c: eth_tx_data0 <= wdata, ignored unless FSM is IDLE
  - 0x830: eth_tx_data1 <= wdata, ignored unless FSM is IDLE
  - 0x834: any write clears eth_send_finish
  - 0x83c: send command; wdata[0]==1 starts a send if FSM is IDLE, otherwise ignored
  - Any other 0x8xx address, including the read-only 0x808/0x80c/0x814/0x820/0x824/0x828: write dropped, no side effect.
- Ethernet FSM:
  - IDLE: a valid send command moves to REQ.
  - REQ: eth_tx_valid=1. On eth_tx_valid & eth_tx_ready, move to WAIT.
  - WAIT: eth_tx_valid=0. On eth_tx_done, set eth_send_finish and move to IDLE.
  - eth_tx_done in IDLE or REQ is ignored.
- eth_busy = (state != IDLE).
- eth_tx_data0/1 are held stable from command acceptance until the FSM returns to IDLE.

## Timing
- dmem_we is combinational, zero latency.
- Peripheral registers update at the rising edge where we=1. New values are visible the next cycle.
- Send command at edge N puts the FSM in REQ, so eth_tx_valid is high in cycle N+1.
- eth_tx_valid stays high until the ready edge, then deasserts at the following cycle.
- eth_send_finish and eth_busy=0 are both visible the cycle after the eth_tx_done edge.
- Same-cycle eth_tx_done and write to 0x834: set wins, eth_send_finish=1.
- Send command in the same cycle WAIT sees eth_tx_done: command ignored, because state is not IDLE at that edge.
- Starting a new send does not clear eth_send_finish. Only a 0x834 write clears it.
- Reset is asynchronous and valid mid-send:
  - FSM -> IDLE, all outputs 0: seg_data, led, timer_load, timer_load_pulse, eth_tx_data0/1, eth_tx_valid, eth_busy, eth_send_finish.
  - Any in-flight MAC handshake is abandoned.

## Test plan
- sw 0x12345678 to 0x004 -> dmem_we=1 that cycle. Store to 0x804 -> dmem_we=0.
- sw 0xFFFFABCD to 0x804, then 0x0000_00FF to 0x800 -> led=0xABCD, seg_data=0xFF. Stores to 0x808 and 0x8F0 leave all registers unchanged.
- sw 0x000003E8 to 0x810 -> timer_load=0x3E8 and timer_load_pulse high for exactly one cycle.
- Ethernet send:
  - Stimulus: data0=0xAAAA0001, data1=0xBBBB0002, command 1 to 0x83c; hold eth_tx_ready=0 for 3 cycles, then 1; pulse eth_tx_done 5 cycles later.
  - Response: valid held 4 cycles, data stable, busy during REQ/WAIT, finish=1 after done.
  - A data write or second command during busy has no effect. A write to 0x834 then clears finish.
- Clear-vs-set collision: 0x834 write on the eth_tx_done cycle -> eth_send_finish=1.
- Assert rst while in REQ -> eth_tx_valid=0 immediately (asynchronous). All registers read 0 and FSM is IDLE after release.

Source files
------------

// File: rtl/store_dispatch.sv
// MEM-stage store decoder: routes each sw to DMEM or a peripheral register,
// and runs the Ethernet transmit request/completion handshake.
module store_dispatch #(
   parameter int LED_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic             we,
   output logic             dmem_we,
   output logic [31:0]      seg_data,
   output logic [LED_W-1:0] led,
   output logic [31:0]      timer_load,
   output logic             timer_load_pulse,
   output logic [31:0]      eth_tx_data0,
   output logic [31:0]      eth_tx_data1,
   output logic             eth_tx_valid,
   input  logic             eth_tx_ready,
   input  logic             eth_tx_done,
   output logic             eth_busy,
   output logic             eth_send_finish
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } eth_state_t;

   eth_state_t state, state_nx;

   logic sel_seg, sel_led, sel_tmr;
   logic sel_d0, sel_d1, sel_clr, sel_cmd;
   logic idle, start;
   logic unused_addr;

   assign unused_addr = ^{addr[31:12], addr[1:0]};

   assign dmem_we = we & ~addr[11];

   always_comb begin
      sel_seg = 1'b0;
      sel_led = 1'b0;
      sel_tmr = 1'b0;
      sel_d0  = 1'b0;
      sel_d1  = 1'b0;
      sel_clr = 1'b0;
      sel_cmd = 1'b0;
      if (we && addr[11]) begin
         case (addr[11:2])
            10'h200: sel_seg = 1'b1;
            10'h201: sel_led = 1'b1;
            10'h204: sel_tmr = 1'b1;
            10'h20b: sel_d0  = 1'b1;
            10'h20c: sel_d1  = 1'b1;
            10'h20d: sel_clr = 1'b1;
            10'h20f: sel_cmd = 1'b1;
            default: ;
         endcase
      end
   end

   assign idle  = (state == IDLE);
   assign start = sel_cmd & wdata[0] & idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_data         <= '0;
         led              <= '0;
         timer_load       <= '0;
         timer_load_pulse <= 1'b0;
      end else begin
         timer_load_pulse <= sel_tmr;
         if (sel_seg) seg_data <= wdata;
         if (sel_led) led <= wdata[LED_W-1:0];
         if (sel_tmr) timer_load <= wdata;
      end
   end

   // staging words freeze once a send is in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eth_tx_data0 <= '0;
         eth_tx_data1 <= '0;
      end else begin
         if (sel_d0 && idle) eth_tx_data0 <= wdata;
         if (sel_d1 && idle) eth_tx_data1 <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         eth_send_finish <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == WAIT && eth_tx_done)
            eth_send_finish <= 1'b1;
         else if (sel_clr)
            eth_send_finish <= 1'b0;
      end
   end

   always_comb begin
      state_nx     = state;
      eth_tx_valid = 1'b0;
      unique case (state)
         IDLE: if (start) state_nx = REQ;
         REQ: begin
            eth_tx_valid = 1'b1;
            if (eth_tx_ready) state_nx = WAIT;
         end
         WAIT: if (eth_tx_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign eth_busy = ~idle;

endmodule

// File: tb/tb_store_dispatch.sv
// Directed bench for store_dispatch: decode table plus Ethernet
// handshake, clear/set collision and async reset sequences.
module tb_store_dispatch;

   localparam int LED_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic             we;
   logic             dmem_we;
   logic [31:0]      seg_data;
   logic [LED_W-1:0] led;
   logic [31:0]      timer_load;
   logic             timer_load_pulse;
   logic [31:0]      eth_tx_data0;
   logic [31:0]      eth_tx_data1;
   logic             eth_tx_valid;
   logic             eth_tx_ready;
   logic             eth_tx_done;
   logic             eth_busy;
   logic             eth_send_finish;

   store_dispatch #(.LED_W(LED_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .addr             (addr),
      .wdata            (wdata),
      .we               (we),
      .dmem_we          (dmem_we),
      .seg_data         (seg_data),
      .led              (led),
      .timer_load       (timer_load),
      .timer_load_pulse (timer_load_pulse),
      .eth_tx_data0     (eth_tx_data0),
      .eth_tx_data1     (eth_tx_data1),
      .eth_tx_valid     (eth_tx_valid),
      .eth_tx_ready     (eth_tx_ready),
      .eth_tx_done      (eth_tx_done),
      .eth_busy         (eth_busy),
      .eth_send_finish  (eth_send_finish)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic        dm;
      logic [31:0] seg;
      logic [15:0] led;
      logic [31:0] tl;
      logic        pulse;
   } vec_t;

   vec_t vt[10];
   int   vcnt;

   initial begin
      vt[0] = '{32'h0000_0004, 32'h1234_5678, 1'b1, 32'h0,  16'h0,    32'h0,   1'b0};
      vt[1] = '{32'h0000_0804, 32'hFFFF_ABCD, 1'b0, 32'h0,  16'hABCD, 32'h0,   1'b0};
      vt[2] = '{32'h0000_0800, 32'h0000_00FF, 1'b0, 32'hFF, 16'hABCD, 32'h0,   1'b0};
      vt[3] = '{32'h0000_0808, 32'hDEAD_0000, 1'b0, 32'hFF, 16'hABCD, 32'h0,   1'b0};
      vt[4] = '{32'h0000_08F0, 32'hBEEF_0000, 1'b0, 32'hFF, 16'hABCD, 32'h0,   1'b0};
      vt[5] = '{32'hFFFF_F004, 32'h5555_5555, 1'b1, 32'hFF, 16'hABCD, 32'h0,   1'b0};
      vt[6] = '{32'h1234_5806, 32'h0000_1234, 1'b0, 32'hFF, 16'h1234, 32'h0,   1'b0};
      vt[7] = '{32'h0000_0810, 32'h0000_03E8, 1'b0, 32'hFF, 16'h1234, 32'h3E8, 1'b1};
      vt[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFF, 16'h1234, 32'h3E8, 1'b0};
      vt[9] = '{32'h0000_080C, 32'h0000_0007, 1'b0, 32'hFF, 16'h1234, 32'h3E8, 1'b0};

      rst = 1'b1; addr = '0; wdata = '0; we = 1'b0;
      eth_tx_ready = 1'b0; eth_tx_done = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst seg", seg_data, 32'h0);
      chk("rst led", {16'h0, led}, 32'h0);
      chk("rst timer", timer_load, 32'h0);
      chk("rst busy", {31'h0, eth_busy}, 32'h0);
      chk("rst finish", {31'h0, eth_send_finish}, 32'h0);

      // decode table
      for (int i = 0; i < 10; i++) begin
         addr = vt[i].a; wdata = vt[i].d; we = 1'b1;
         #1;
         chk($sformatf("v%0d dmem_we", i), {31'h0, dmem_we}, {31'h0, vt[i].dm});
         @(posedge clk); #1;
         we = 1'b0;
         chk($sformatf("v%0d seg", i), seg_data, vt[i].seg);
         chk($sformatf("v%0d led", i), {16'h0, led}, {16'h0, vt[i].led});
         chk($sformatf("v%0d timer", i), timer_load, vt[i].tl);
         chk($sformatf("v%0d pulse", i), {31'h0, timer_load_pulse}, {31'h0, vt[i].pulse});
      end
      chk("tbl data0", eth_tx_data0, 32'h0);

      // send with wdata[0]=0 does nothing
      sw(32'h83C, 32'h2);
      chk("cmd bit0 clear", {31'h0, eth_busy}, 32'h0);

      // main send
      sw(32'h82C, 32'hAAAA_0001);
      sw(32'h830, 32'hBBBB_0002);
      chk("data0 staged", eth_tx_data0, 32'hAAAA_0001);
      chk("data1 staged", eth_tx_data1, 32'hBBBB_0002);
      sw(32'h83C, 32'h1);
      vcnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (eth_tx_valid) vcnt++;
         chk("req busy", {31'h0, eth_busy}, 32'h1);
         if (i == 0) begin addr = 32'h82C; wdata = 32'h1111_1111; we = 1'b1; end
         if (i == 1) begin addr = 32'h83C; wdata = 32'h1; we = 1'b1; end
         if (i == 2) begin we = 1'b0; eth_tx_done = 1'b1; end
         tick();
         we = 1'b0; eth_tx_done = 1'b0;
      end
      eth_tx_ready = 1'b1;
      if (eth_tx_valid) vcnt++;
      tick();
      eth_tx_ready = 1'b0;
      chk("valid cycles", vcnt, 4);
      chk("wait valid", {31'h0, eth_tx_valid}, 32'h0);
      chk("wait busy", {31'h0, eth_busy}, 32'h1);
      sw(32'h830, 32'h2222_2222);
      for (int i = 0; i < 3; i++) tick();
      chk("wait finish", {31'h0, eth_send_finish}, 32'h0);
      chk("busy data0", eth_tx_data0, 32'hAAAA_0001);
      chk("busy data1", eth_tx_data1, 32'hBBBB_0002);
      eth_tx_done = 1'b1;
      tick();
      eth_tx_done = 1'b0;
      chk("done finish", {31'h0, eth_send_finish}, 32'h1);
      chk("done busy", {31'h0, eth_busy}, 32'h0);
      chk("done valid", {31'h0, eth_tx_valid}, 32'h0);

      // new send keeps finish; done during REQ was tested above
      sw(32'h83C, 32'h1);
      chk("send2 valid", {31'h0, eth_tx_valid}, 32'h1);
      chk("send2 finish kept", {31'h0, eth_send_finish}, 32'h1);
      eth_tx_ready = 1'b1;
      tick();
      eth_tx_ready = 1'b0;
      addr = 32'h834; wdata = 32'h0; we = 1'b1; eth_tx_done = 1'b1;
      tick();
      we = 1'b0; eth_tx_done = 1'b0;
      chk("collide finish", {31'h0, eth_send_finish}, 32'h1);
      sw(32'h834, 32'h0);
      chk("clear finish", {31'h0, eth_send_finish}, 32'h0);

      // command on the same edge WAIT sees done is dropped
      sw(32'h83C, 32'h1);
      eth_tx_ready = 1'b1;
      tick();
      eth_tx_ready = 1'b0;
      addr = 32'h83C; wdata = 32'h1; we = 1'b1; eth_tx_done = 1'b1;
      tick();
      we = 1'b0; eth_tx_done = 1'b0;
      chk("cmd at done busy", {31'h0, eth_busy}, 32'h0);
      chk("cmd at done fin", {31'h0, eth_send_finish}, 32'h1);

      // async reset while in REQ
      sw(32'h83C, 32'h1);
      chk("pre-rst valid", {31'h0, eth_tx_valid}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async valid", {31'h0, eth_tx_valid}, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("post seg", seg_data, 32'h0);
      chk("post led", {16'h0, led}, 32'h0);
      chk("post timer", timer_load, 32'h0);
      chk("post data0", eth_tx_data0, 32'h0);
      chk("post data1", eth_tx_data1, 32'h0);
      chk("post busy", {31'h0, eth_busy}, 32'h0);
      chk("post finish", {31'h0, eth_send_finish}, 32'h0);
      chk("post valid", {31'h0, eth_tx_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
